// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-requester BRAM port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshake bundle: one instance per requester (A, B).
interface mem_port_arbiter_if #(
  parameter int WID_MEM = 32
);
  logic               req;
  logic               we;
  logic [31:0]        addr;
  logic [WID_MEM-1:0] wdata;
  logic               gnt;
  logic               err;
  logic               rvalid;
  logic [WID_MEM-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, err, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, err, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; after a contested grant the loser is favoured.
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic prio_b_q, prio_b_d;

  always_comb begin
    gnt_a    = en & req_a & (~req_b | ~prio_b_q);
    gnt_b    = en & req_b & (~req_a |  prio_b_q);
    prio_b_d = prio_b_q;
    if (en & req_a & req_b) prio_b_d = gnt_a;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prio_b_q <= 1'b0;
    else        prio_b_q <= prio_b_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one simple-dual-port BRAM between requesters A and B, with a
// full-memory clear engine.
//   state | meaning
//   IDLE  | arbitrate reads and writes from A and B
//   CLEAR | sweep every word to CLEAR_VAL, no grants
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                 WID_MEM   = 32,
  parameter int                 DEPTH_MEM = 512,
  parameter int                 ADDR_W    = $clog2(DEPTH_MEM),
  parameter logic [WID_MEM-1:0] CLEAR_VAL = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_start,
  output logic                clear_busy,
  output logic                clear_done,
  mem_port_arbiter_if.slave   a_port,
  mem_port_arbiter_if.slave   b_port,
  output logic [ADDR_W-1:0]   mem_raddr,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic                mem_we,
  output logic [WID_MEM-1:0]  mem_din,
  input  logic [WID_MEM-1:0]  mem_dout
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              clear_done_q, clear_done_d;
  logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic              a_err_q, a_err_d, b_err_q, b_err_d;

  logic grant_en;
  logic a_in, b_in;
  logic a_rd_req, b_rd_req, a_wr_req, b_wr_req;
  logic a_rd_gnt, b_rd_gnt, a_wr_gnt, b_wr_gnt;

  // clear_start wins over any request in the same cycle
  assign grant_en = (state_q == IDLE) && !clear_start;
  assign a_in     = addr_in_range(a_port.addr, DEPTH_MEM);
  assign b_in     = addr_in_range(b_port.addr, DEPTH_MEM);
  assign a_rd_req = a_port.req & ~a_port.we;
  assign b_rd_req = b_port.req & ~b_port.we;
  assign a_wr_req = a_port.req &  a_port.we;
  assign b_wr_req = b_port.req &  b_port.we;

  rr_arb2 u_rd_arb (
    .clk   (clk),
    .reset (reset),
    .en    (grant_en),
    .req_a (a_rd_req),
    .req_b (b_rd_req),
    .gnt_a (a_rd_gnt),
    .gnt_b (b_rd_gnt)
  );

  rr_arb2 u_wr_arb (
    .clk   (clk),
    .reset (reset),
    .en    (grant_en),
    .req_a (a_wr_req),
    .req_b (b_wr_req),
    .gnt_a (a_wr_gnt),
    .gnt_b (b_wr_gnt)
  );

  always_comb begin
    mem_raddr = '0;
    mem_waddr = '0;
    mem_we    = 1'b0;
    mem_din   = '0;
    if (a_rd_gnt && a_in)      mem_raddr = a_port.addr[ADDR_W-1:0];
    else if (b_rd_gnt && b_in) mem_raddr = b_port.addr[ADDR_W-1:0];
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_din   = CLEAR_VAL;
    end else if (a_wr_gnt && a_in) begin
      mem_we    = 1'b1;
      mem_waddr = a_port.addr[ADDR_W-1:0];
      mem_din   = a_port.wdata;
    end else if (b_wr_gnt && b_in) begin
      mem_we    = 1'b1;
      mem_waddr = b_port.addr[ADDR_W-1:0];
      mem_din   = b_port.wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    clear_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        if (ptr_q == LAST_ADDR) begin
          state_d      = IDLE;
          ptr_d        = '0;
          clear_done_d = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Out-of-range reads still return rvalid so requesters never stall waiting
  always_comb begin
    a_rvalid_d = a_rd_gnt;
    b_rvalid_d = b_rd_gnt;
    a_err_d    = (a_rd_gnt | a_wr_gnt) & ~a_in;
    b_err_d    = (b_rd_gnt | b_wr_gnt) & ~b_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      clear_done_q <= 1'b0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      a_err_q      <= 1'b0;
      b_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      clear_done_q <= clear_done_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
      a_err_q      <= a_err_d;
      b_err_q      <= b_err_d;
    end
  end

  assign clear_busy    = (state_q == CLEAR);
  assign clear_done    = clear_done_q;
  assign a_port.gnt    = a_rd_gnt | a_wr_gnt;
  assign b_port.gnt    = b_rd_gnt | b_wr_gnt;
  assign a_port.err    = a_err_q;
  assign b_port.err    = b_err_q;
  assign a_port.rvalid = a_rvalid_q;
  assign b_port.rvalid = b_rvalid_q;
  assign a_port.rdata  = mem_dout;
  assign b_port.rdata  = mem_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural BRAM, transaction-level reference
// model, directed scenarios then randomized held-until-granted traffic.
module tb_mem_port_arbiter;

  localparam int WID   = 32;
  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_start = 1'b0;
  logic          clear_busy, clear_done;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic          mem_we;
  logic [31:0]   mem_din, mem_dout;

  mem_port_arbiter_if #(.WID_MEM(WID)) a_if ();
  mem_port_arbiter_if #(.WID_MEM(WID)) b_if ();

  mem_port_arbiter #(
    .WID_MEM   (WID),
    .DEPTH_MEM (DEPTH),
    .CLEAR_VAL ('0)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .a_port      (a_if),
    .b_port      (b_if),
    .mem_raddr   (mem_raddr),
    .mem_waddr   (mem_waddr),
    .mem_we      (mem_we),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout)
  );

  always #5 clk = ~clk;

  // read-first simple-dual-port RAM
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_din;
    mem_dout <= ram[mem_raddr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model state
  int          m_clear_left;
  bit          m_done;
  bit          m_rr_rd, m_rr_wr;      // 1 = next contest goes to B
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          m_a_rv, m_a_err, m_a_rk, m_b_rv, m_b_err, m_b_rk;
  logic [31:0] m_a_rd, m_b_rd;

  // observations from the latest step
  bit          obs_ga, obs_gb, obs_we, obs_busy, obs_done;
  bit          obs_a_rv, obs_a_err;
  logic [31:0] last_a_rdata, last_b_rdata;
  int          nz_cnt;

  task automatic model_reset();
    m_clear_left = 0;
    m_done = 0;
    m_rr_rd = 0;
    m_rr_wr = 0;
    m_a_rv = 0; m_a_err = 0; m_a_rk = 0;
    m_b_rv = 0; m_b_err = 0; m_b_rk = 0;
  endtask

  // One clock cycle: check at negedge against the model, then advance it.
  task automatic step();
    bit busy, ga_r, gb_r, ga_w, gb_w, a_ok, b_ok, exp_we;
    int idx;
    @(negedge clk);
    busy = (m_clear_left > 0);
    chk("clear_busy", clear_busy, busy);
    chk("clear_done", clear_done, m_done);
    chk("a_rvalid", a_if.rvalid, m_a_rv);
    chk("a_err", a_if.err, m_a_err);
    if (m_a_rv && m_a_rk) chk("a_rdata", a_if.rdata, m_a_rd);
    chk("b_rvalid", b_if.rvalid, m_b_rv);
    chk("b_err", b_if.err, m_b_err);
    if (m_b_rv && m_b_rk) chk("b_rdata", b_if.rdata, m_b_rd);
    if (busy) begin
      chk("clear_addr", mem_waddr, DEPTH - m_clear_left);
      chk("clear_din", mem_din, 0);
    end

    ga_r = 0; gb_r = 0; ga_w = 0; gb_w = 0;
    if (!busy && !clear_start) begin
      if (a_if.req && !a_if.we && b_if.req && !b_if.we) begin
        if (m_rr_rd) gb_r = 1; else ga_r = 1;
        m_rr_rd = ga_r;
      end else begin
        ga_r = a_if.req && !a_if.we;
        gb_r = b_if.req && !b_if.we;
      end
      if (a_if.req && a_if.we && b_if.req && b_if.we) begin
        if (m_rr_wr) gb_w = 1; else ga_w = 1;
        m_rr_wr = ga_w;
      end else begin
        ga_w = a_if.req && a_if.we;
        gb_w = b_if.req && b_if.we;
      end
    end
    a_ok = (a_if.addr < DEPTH);
    b_ok = (b_if.addr < DEPTH);
    exp_we = busy || (ga_w && a_ok) || (gb_w && b_ok);
    chk("a_gnt", a_if.gnt, ga_r | ga_w);
    chk("b_gnt", b_if.gnt, gb_r | gb_w);
    chk("mem_we", mem_we, exp_we);

    obs_ga = a_if.gnt; obs_gb = b_if.gnt; obs_we = mem_we;
    obs_busy = clear_busy; obs_done = clear_done;
    obs_a_rv = a_if.rvalid; obs_a_err = a_if.err;
    if (a_if.rvalid) begin
      last_a_rdata = a_if.rdata;
      if (!a_if.err && a_if.rdata != 0) nz_cnt++;
    end
    if (b_if.rvalid) begin
      last_b_rdata = b_if.rdata;
      if (!b_if.err && b_if.rdata != 0) nz_cnt++;
    end

    // reads see memory before this cycle's write
    m_a_rv = ga_r; m_a_err = (ga_r | ga_w) && !a_ok; m_a_rk = 0;
    m_b_rv = gb_r; m_b_err = (gb_r | gb_w) && !b_ok; m_b_rk = 0;
    if (ga_r && a_ok) begin
      m_a_rk = m_known[a_if.addr[8:0]];
      m_a_rd = m_mem[a_if.addr[8:0]];
    end
    if (gb_r && b_ok) begin
      m_b_rk = m_known[b_if.addr[8:0]];
      m_b_rd = m_mem[b_if.addr[8:0]];
    end
    if (ga_w && a_ok) begin
      m_mem[a_if.addr[8:0]] = a_if.wdata;
      m_known[a_if.addr[8:0]] = 1;
    end
    if (gb_w && b_ok) begin
      m_mem[b_if.addr[8:0]] = b_if.wdata;
      m_known[b_if.addr[8:0]] = 1;
    end
    m_done = 0;
    if (busy) begin
      idx = DEPTH - m_clear_left;
      m_mem[idx] = 0;
      m_known[idx] = 1;
      m_clear_left--;
      if (m_clear_left == 0) m_done = 1;
    end else if (clear_start) begin
      m_clear_left = DEPTH;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input bit we, input int unsigned addr, input logic [31:0] data);
    a_if.req = 1; a_if.we = we; a_if.addr = addr; a_if.wdata = data;
  endtask

  task automatic set_b(input bit we, input int unsigned addr, input logic [31:0] data);
    b_if.req = 1; b_if.we = we; b_if.addr = addr; b_if.wdata = data;
  endtask

  task automatic drop_granted();
    if (obs_ga) a_if.req = 0;
    if (obs_gb) b_if.req = 0;
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n = 0;
    while ((a_if.req || b_if.req) && n < max_cycles) begin
      step();
      drop_granted();
      n++;
    end
    chk("grant_timeout", {a_if.req, b_if.req}, 0);
    a_if.req = 0;
    b_if.req = 0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt, gnt_in_busy;
    a_if.req = 0; a_if.we = 0; a_if.addr = 0; a_if.wdata = 0;
    b_if.req = 0; b_if.we = 0; b_if.addr = 0; b_if.wdata = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_known[i] = 0;
      m_mem[i] = 0;
    end
    model_reset();
    nz_cnt = 0;

    @(negedge clk);
    chk("rst_busy", clear_busy, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_a_rvalid", a_if.rvalid, 0);
    chk("rst_b_err", b_if.err, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_raddr", mem_raddr, 0);
    chk("rst_waddr", mem_waddr, 0);
    chk("rst_din", mem_din, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // write then read back through the other requester
    set_a(1, 5, 32'hDEADBEEF);
    step();
    chk("t1_wr_gnt", obs_ga, 1);
    a_if.req = 0;
    set_b(0, 5, 0);
    step();
    chk("t1_rd_gnt", obs_gb, 1);
    b_if.req = 0;
    step();
    chk("t1_rdata", last_b_rdata, 32'hDEADBEEF);

    // sustained read contention alternates A,B,...
    set_a(0, 5, 0);
    set_b(0, 5, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t2_a_turn", obs_ga, (i % 2) == 0);
      chk("t2_single", obs_ga & obs_gb, 0);
    end
    a_if.req = 0; b_if.req = 0;
    step();

    // read-first on same-address read/write
    set_a(1, 3, 32'h55);
    run_until_idle(5);
    set_a(0, 3, 0);
    set_b(1, 3, 32'h1234);
    step();
    chk("t3_both_gnt", {obs_ga, obs_gb}, 2'b11);
    drop_granted();
    step();
    chk("t3_old_data", last_a_rdata, 32'h55);
    set_a(0, 3, 0);
    run_until_idle(5);
    chk("t3_new_data", last_a_rdata, 32'h1234);

    // fill, clear, read back
    for (int i = 0; i < DEPTH; i++) begin
      set_a(1, i, 32'hA5000000 | i);
      step();
      drop_granted();
    end
    step();
    clear_start = 1;
    step();
    clear_start = 0;
    set_a(0, 10, 0);
    set_b(0, 20, 0);
    busy_cnt = 0; done_cnt = 0; gnt_in_busy = 0;
    for (int k = 0; k < 530; k++) begin
      step();
      if (obs_busy) busy_cnt++;
      if (obs_busy && (obs_ga || obs_gb)) gnt_in_busy++;
      if (obs_done) done_cnt++;
      drop_granted();
    end
    chk("t4_busy_cycles", busy_cnt, DEPTH);
    chk("t4_done_pulses", done_cnt, 1);
    chk("t4_gnt_in_busy", gnt_in_busy, 0);
    nz_cnt = 0;
    for (int i = 0; i < DEPTH; i += 2) begin
      set_a(0, i, 0);
      set_b(0, i + 1, 0);
      run_until_idle(6);
    end
    chk("t4_nonzero_reads", nz_cnt, 0);

    // out-of-range access
    set_a(1, 600, 32'hFFFF);
    step();
    chk("t5_wr_gnt", obs_ga, 1);
    chk("t5_wr_we", obs_we, 0);
    a_if.req = 0;
    step();
    chk("t5_wr_err", obs_a_err, 1);
    set_a(0, 600, 0);
    step();
    a_if.req = 0;
    step();
    chk("t5_rd_rvalid", obs_a_rv, 1);
    chk("t5_rd_err", obs_a_err, 1);

    // reset in the middle of a clear sweep
    clear_start = 1;
    step();
    clear_start = 0;
    for (int k = 0; k < 100; k++) step();
    chk("t6_sweep_addr", mem_waddr, 100);
    rst_n = 0;
    #1;
    chk("t6_busy_drop", clear_busy, 0);
    chk("t6_no_done", clear_done, 0);
    chk("t6_we_drop", mem_we, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    set_a(1, 7, 32'h77);
    set_b(0, 3, 0);
    step();
    chk("t6_post_gnt_a", obs_ga, 1);
    chk("t6_post_gnt_b", obs_gb, 1);
    drop_granted();
    run_until_idle(5);

    // randomized traffic
    for (int k = 0; k < 2500; k++) begin
      if (!a_if.req && $urandom_range(0, 3) != 0)
        set_a($urandom_range(0, 1), ($urandom_range(0, 19) == 0) ?
              $urandom_range(512, 700) : $urandom_range(0, 15), $urandom);
      if (!b_if.req && $urandom_range(0, 3) != 0)
        set_b($urandom_range(0, 1), ($urandom_range(0, 19) == 0) ?
              $urandom_range(512, 700) : $urandom_range(0, 15), $urandom);
      clear_start = ($urandom_range(0, 799) == 0);
      step();
      clear_start = 0;
      drop_granted();
    end
    run_until_idle(1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one simple-dual-port block RAM (one read port, one write port, registered read, 1-cycle latency) between two requesters, A and B, and adds a built-in clear engine that sweeps every word to a fixed value. It sits between the requesters and the BRAM wrapper and drives that wrapper's read address, write address, write data and write enable. The RAM must expose a write enable; the arbiter never relies on idle-cycle writes being harmless.

## Interface
- WID_MEM, 32, data width
- DEPTH_MEM, 512, number of words
- ADDR_W, $clog2(DEPTH_MEM), RAM address width
- CLEAR_VAL, '0, word written by the clear engine

- clk  in  1  clock, all logic on posedge
- reset  in  1  asynchronous, active-low reset
- clear_start  in  1  one-cycle pulse that starts a full-memory clear
- clear_busy  out  1  clear sweep in progress
- clear_done  out  1  one-cycle pulse after the last clear write
- a_req / b_req  in  1  transaction request, held until granted
- a_we / b_we  in  1  1 = write, 0 = read
- a_addr / b_addr  in  32  word address
- a_wdata / b_wdata  in  WID_MEM  write data
- a_gnt / b_gnt  out  1  transaction accepted this cycle (combinational)
- a_err / b_err  out  1  registered pulse: granted access was out of range
- a_rvalid / b_rvalid  out  1  read data valid
- a_rdata / b_rdata  out  WID_MEM  read data (mem_dout fanned out)
- mem_raddr  out  ADDR_W  RAM read address
- mem_waddr  out  ADDR_W  RAM write address
- mem_we  out  1  RAM write enable
- mem_din  out  WID_MEM  RAM write data
- mem_dout  in  WID_MEM  RAM registered read data

## Operation
- FSM states: IDLE, CLEAR.
- IDLE
  - Each cycle, grant at most one read and at most one write.
  - A read from one requester and a write from the other are both granted in the same cycle.
  - Same-class contention (both reading or both writing) is resolved by that class's round-robin bit. After a contested grant, the bit favours the loser. Uncontested grants leave the bit unchanged.
  - Both bits favour A out of reset.
- Request rules
  - A requester holds req, we, addr and wdata stable until it sees gnt.
  - The transaction happens in the gnt cycle.
- Out-of-range access (addr >= DEPTH_MEM)
  - It is granted but dropped: mem_we stays 0, or no read is issued.
  - err pulses the next cycle.
  - For a read, rvalid also pulses with rdata don't-care.
- Read-during-write to the same address returns old data (read-first). No forwarding.
- IDLE to CLEAR
  - Taken when clear_start is high in IDLE. clear_start has priority: no grants in that cycle.
  - clear_start while in CLEAR is ignored.
- CLEAR
  - A pointer runs 0..DEPTH_MEM-1, one write of CLEAR_VAL per cycle with mem_we = 1.
  - No grants are made.
  - After the write to DEPTH_MEM-1: pulse clear_done, return to IDLE, reset the pointer to 0.
- A read granted in the cycle before CLEAR entry still returns its rvalid.
- Reset values: clear_busy, clear_done, err, rvalid, mem_we all 0; FSM in IDLE; pointer 0; round-robin bits favour A. mem_raddr, mem_waddr, mem_din are 0 when idle.
- Reset mid-clear: the FSM returns to IDLE immediately. RAM contents are partially cleared and not guaranteed; no clear_done is issued.

## Timing
- gnt is combinational from req, the FSM state and the round-robin bits.
- Read latency: granted in cycle N, so rvalid and rdata are valid in cycle N+1. rvalid is a registered copy of "read granted in range or out of range".
- A write granted in cycle N updates the RAM at the end of cycle N and is visible to a read granted in cycle N+1.
- Clear: clear_start in cycle N, then clear_busy is high in cycles N+1..N+DEPTH_MEM, with the address equal to cycle index minus N+1.
- clear_done pulses in cycle N+DEPTH_MEM+1, and grants resume in that same cycle.
- Back-to-back: each requester can be granted every cycle. With sustained contention in one class, grants alternate A, B, A, B.

## Structure
- Package mem_arb_pkg holds:
  - typedef arb_state_t {IDLE, CLEAR};
  - a localparam function for the address-range check.
- One natural sub-module, rr_arb2: a two-input round-robin arbiter with a priority flip-flop.
  - It is instantiated twice, once for the read class and once for the write class.

## Test plan
- After reset: A writes 0xDEADBEEF to address 5 and is granted the same cycle. The next cycle B reads address 5, and b_rvalid plus b_rdata=0xDEADBEEF appear one cycle after b_gnt.
- A and B both read continuously for 6 cycles. Grants go A,B,A,B,A,B, each rvalid trails its gnt by 1, and there is no double grant.
- A reads address 3 while B writes 0x1234 to address 3 in the same cycle. Both are granted and a_rdata returns the old value. A later read returns 0x1234.
- Fill addresses 0..511 with a nonzero pattern, then pulse clear_start.
  - clear_busy is high for exactly 512 cycles, requests issued during that time are not granted, and clear_done pulses once.
  - All 512 reads afterwards return CLEAR_VAL.
- A writes to address 600: granted, a_err pulses next cycle, mem_we stays 0. A read of address 600 gives an a_rvalid pulse and an a_err pulse.
- Pulse clear_start, then assert reset for 1 cycle at sweep address 100. clear_busy drops immediately, no clear_done, and requests are granted in the first cycle after reset is released.
